mdv_ctrl: RTL

Microdrive drive controller between the ZX8302 microdrive control bits and up to eight `mdv` replay units. It decodes the serial drive-select shift register into a single active drive, models motor spin-up before the drive delivers data, and muxes that drive's `gap`/`rx_ready`/`dout` back to the IPC/CPU side. It also steers the image download port to the addressed drive, holding that drive deselected while its image is being loaded.

---
 rtl/mdv_pkg.sv | 15 +
 rtl/mdv_sel_sr.sv | 42 ++++
 rtl/mdv_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/mdv_pkg.sv
// Shared definitions for the microdrive controller: state encoding and sizing constants.
package mdv_pkg;

   localparam int unsigned MDV_MAX_DRIVES     = 8;
   localparam int unsigned MDV_SPINUP_DEFAULT = 7500;
   localparam int unsigned MDV_CNT_W          = 20;
   localparam int unsigned MDV_IDX_W          = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPINUP = 2'd1,
      ST_RUN    = 2'd2
   } mdv_state_t;

endpackage

// File: rtl/mdv_sel_sr.sv
// Drive-select shift register: MDSELCK edge detect, 8-bit shifter, lowest-set-bit target encoder.
module mdv_sel_sr
   import mdv_pkg::*;
#(
   parameter int unsigned NDRIVES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sel_clk,
   input  logic                 sel_data,
   output logic [MDV_IDX_W-1:0] target,
   output logic                 target_valid
);

   logic                      sel_clk_q;
   logic [MDV_MAX_DRIVES-1:0] sr;
   logic [NDRIVES:0]          seen;
   logic [NDRIVES:0][MDV_IDX_W-1:0] idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_clk_q <= 1'b0;
         sr        <= '0;
      end else begin
         sel_clk_q <= sel_clk;
         if (sel_clk && !sel_clk_q)
            sr <= {sr[MDV_MAX_DRIVES-2:0], sel_data};
      end
   end

   // Priority chain: the first set bit from drive 0 upward claims the target.
   assign seen[0] = 1'b0;
   assign idx[0]  = '0;
   for (genvar g = 0; g < NDRIVES; g++) begin : g_enc
      assign seen[g+1] = seen[g] | sr[g];
      assign idx[g+1]  = (!seen[g] && sr[g]) ? MDV_IDX_W'(g) : idx[g];
   end

   assign target       = idx[NDRIVES];
   assign target_valid = seen[NDRIVES];

endmodule

// File: rtl/mdv_ctrl.sv
// Microdrive controller: drive selection FSM with spin-up delay, return-path mux and download steering.
module mdv_ctrl
   import mdv_pkg::*;
#(
   parameter int unsigned NDRIVES = 2,
   parameter int unsigned SPINUP  = MDV_SPINUP_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic                   sel_clk,
   input  logic                   sel_data,
   output logic [NDRIVES-1:0]     drv_sel,
   output logic                   motor_on,
   output logic [MDV_IDX_W-1:0]   active,
   input  logic [NDRIVES-1:0]     drv_gap,
   input  logic [NDRIVES-1:0]     drv_rx_ready,
   input  logic [8*NDRIVES-1:0]   drv_dout,
   output logic                   gap,
   output logic                   rx_ready,
   output logic [7:0]             dout,
   input  logic                   download,
   input  logic [MDV_IDX_W-1:0]   dl_drive,
   input  logic                   dl_wr,
   output logic [NDRIVES-1:0]     dl_wr_out,
   output logic [NDRIVES-1:0]     download_out
);

   logic [MDV_IDX_W-1:0] target;
   logic                 target_valid;
   mdv_state_t           state, state_n;
   logic [MDV_IDX_W-1:0] active_n;
   logic [MDV_CNT_W-1:0] cnt, cnt_n;
   logic                 dl_hold;
   logic [NDRIVES-1:0]   sel_n;
   logic [NDRIVES-1:0]   hit;
   logic [NDRIVES:0][7:0] dout_acc;

   mdv_sel_sr #(.NDRIVES(NDRIVES)) u_sel_sr (
      .clk          (clk),
      .reset        (reset),
      .sel_clk      (sel_clk),
      .sel_data     (sel_data),
      .target       (target),
      .target_valid (target_valid)
   );

   // Next state: target loss, target change, download hold, then spin-up counting.
   always_comb begin
      state_n  = state;
      active_n = active;
      cnt_n    = cnt;
      dl_hold  = download && (dl_drive == active);
      if (!target_valid) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
      end else if (state == ST_IDLE || target != active) begin
         state_n  = ST_SPINUP;
         active_n = target;
         cnt_n    = '0;
      end else if (dl_hold) begin
         state_n = ST_SPINUP;
         cnt_n   = '0;
      end else if (state == ST_SPINUP && ce) begin
         if (cnt == MDV_CNT_W'(SPINUP - 1)) begin
            state_n = ST_RUN;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + MDV_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         active   <= '0;
         cnt      <= '0;
         drv_sel  <= '0;
         motor_on <= 1'b0;
      end else begin
         state    <= state_n;
         active   <= active_n;
         cnt      <= cnt_n;
         drv_sel  <= sel_n;
         motor_on <= (state_n != ST_IDLE);
      end
   end

   // Per-drive decode for select, return mux and download steering.
   assign dout_acc[0] = '0;
   for (genvar g = 0; g < NDRIVES; g++) begin : g_drv
      assign sel_n[g]        = (state_n == ST_RUN) && (active_n == MDV_IDX_W'(g));
      assign hit[g]          = (state == ST_RUN) && (active == MDV_IDX_W'(g));
      assign dout_acc[g+1]   = dout_acc[g] | (drv_dout[8*g +: 8] & {8{hit[g]}});
      assign dl_wr_out[g]    = dl_wr && (dl_drive == MDV_IDX_W'(g));
      assign download_out[g] = download && (dl_drive == MDV_IDX_W'(g));
   end

   // A stopped motor reads as a permanent gap with no data.
   assign gap      = (state != ST_RUN) | (|(drv_gap & hit));
   assign rx_ready = |(drv_rx_ready & hit);
   assign dout     = dout_acc[NDRIVES];

endmodule
